// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit with HI/LO result registers.
// Optional divider datapath is built only when MDU_DIV_EN is defined.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_lo_q, neg_lo_d;
   logic             skip_q, skip_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH-1:0] prod, prod_fix;

   // Magnitudes are taken for signed ops; the result sign is restored in DONE.
   assign a_neg   = ~op[0] & a[WIDTH-1];
   assign b_neg   = ~op[0] & b[WIDTH-1];
   assign a_mag   = a_neg ? -a : a;
   assign b_mag   = b_neg ? -b : b;
   assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_lo_q ? -prod : prod;

`ifdef MDU_DIV_EN
   logic             is_div_q, is_div_d;
   logic             neg_hi_q, neg_hi_d;
   logic [WIDTH:0]   div_part, div_trial;
   logic             div_ok;

   assign div_part  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_trial = div_part - {1'b0, opb_q};
   assign div_ok    = (div_part >= {1'b0, opb_q});
`endif

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opb_d      = opb_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      neg_lo_d   = neg_lo_q;
      skip_d     = skip_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
`ifdef MDU_DIV_EN
      is_div_d   = is_div_q;
      neg_hi_d   = neg_hi_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               div_zero_d = 1'b0;
               count_d    = '0;
               skip_d     = 1'b0;
               acc_hi_d   = '0;
               neg_lo_d   = a_neg ^ b_neg;
               if (op[1]) begin
`ifdef MDU_DIV_EN
                  is_div_d = 1'b1;
                  neg_hi_d = a_neg;
                  acc_lo_d = a_mag;
                  opb_d    = b_mag;
                  if (b == '0) begin
                     div_zero_d = 1'b1;
                     skip_d     = 1'b1;
                     state_d    = S_DONE;
                  end else begin
                     state_d = S_RUN;
                  end
`else
                  skip_d  = 1'b1;
                  state_d = S_DONE;
`endif
               end else begin
`ifdef MDU_DIV_EN
                  is_div_d = 1'b0;
`endif
                  acc_lo_d = b_mag;
                  opb_d    = a_mag;
                  state_d  = S_RUN;
               end
            end
         end
         S_RUN: begin
            count_d  = count_q + CW'(1);
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
            if (is_div_q) begin
               acc_hi_d = div_ok ? div_trial[WIDTH-1:0] : div_part[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
            end
`endif
            if (count_q == CW'(WIDTH - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (!skip_q) begin
               {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
               if (is_div_q) begin
                  lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                  hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opb_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         neg_lo_q   <= 1'b0;
         skip_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opb_q      <= opb_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         neg_lo_q   <= neg_lo_d;
         skip_q     <= skip_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
`ifdef MDU_DIV_EN
         is_div_q   <= is_div_d;
         neg_hi_q   <= neg_hi_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule
